// File: rtl/sram_1r1w_ctrl_if.sv
// Request/response bundle for the 1R1W memory controller.
//   W0_*      : write request (enable, address, data, lane mask)
//   R0_en/addr: read request
//   R0_data/R0_valid : read response, valid pulses once per completed read
//   init_busy : clear engine running, requests are dropped while high
// Modports: master drives requests (cache/scratchpad side), slave is the controller.
interface sram_1r1w_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
);
  logic              W0_en;
  logic [ADDR_W-1:0] W0_addr;
  logic [DATA_W-1:0] W0_data;
  logic [MASK_W-1:0] W0_mask;
  logic              R0_en;
  logic [ADDR_W-1:0] R0_addr;
  logic [DATA_W-1:0] R0_data;
  logic              R0_valid;
  logic              init_busy;

  modport master (
    output W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr,
    input  R0_data, R0_valid, init_busy
  );

  modport slave (
    input  W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr,
    output R0_data, R0_valid, init_busy
  );
endinterface

// File: rtl/sram_1r1w_ctrl.sv
// Parametrised 1R1W memory controller with byte-lane masking, selectable
// read latency (1 or 2), write-first forwarding on same-address collisions
// and an optional post-reset clear engine.
// Ports:
//   clock   : rising-edge clock for both ports
//   reset_n : asynchronous active-low reset (array contents are kept)
//   bus     : sram_1r1w_ctrl_if.slave (W0 write port, R0 read port, init_busy)

// One lane of the read-side forwarding mux: new write data wins when the
// write hits the same address and this lane is enabled.
module sram_1r1w_lane #(
  parameter int LW = 8
) (
  input  logic          fwd,
  input  logic [LW-1:0] wdata,
  input  logic [LW-1:0] rdata,
  output logic [LW-1:0] odata
);
  assign odata = fwd ? wdata : rdata;
endmodule

module sram_1r1w_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MASK_W     = 4,
  parameter int RD_LAT     = 1,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  sram_1r1w_ctrl_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int LW    = DATA_W / MASK_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("sram_1r1w_ctrl: RD_LAT must be 1 or 2");
    end
    if (DATA_W % MASK_W != 0) begin : g_bad_mask
      $error("sram_1r1w_ctrl: DATA_W must be a multiple of MASK_W");
    end
  endgenerate

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready, rd_fire, wr_fire, coll;
  logic [MASK_W-1:0] wr_mask;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_raw, rd_fwd;

  // vld_pipe[0] is the accepted read this cycle, vld_pipe[RD_LAT] is R0_valid.
  logic [RD_LAT:1]             vld_q;
  logic [RD_LAT:0]             vld_pipe;
  logic [RD_LAT:1][DATA_W-1:0] dat_q;

  assign ready    = (state == READY);
  assign rd_fire  = ready && bus.R0_en;
  assign wr_fire  = ready && bus.W0_en;
  assign coll     = wr_fire && (bus.W0_addr == bus.R0_addr);
  assign vld_pipe = {vld_q, rd_fire};

  // Clear engine owns the write port outside READY; requests are dropped.
  always_comb begin
    wr_mask = '0;
    wr_addr = bus.W0_addr;
    wr_data = bus.W0_data;
    if (!ready) begin
      wr_mask = '1;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (bus.W0_en) begin
      wr_mask = bus.W0_mask;
    end
  end

  // Storage array: no reset, lane-masked writes.
  always_ff @(posedge clock) begin
    for (int i = 0; i < MASK_W; i++)
      if (wr_mask[i]) mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
  end

  assign rd_raw = mem[bus.R0_addr];

  genvar g;
  generate
    for (g = 0; g < MASK_W; g++) begin : g_lane
      sram_1r1w_lane #(.LW(LW)) u_lane (
        .fwd   (coll && bus.W0_mask[g]),
        .wdata (bus.W0_data[g*LW +: LW]),
        .rdata (rd_raw[g*LW +: LW]),
        .odata (rd_fwd[g*LW +: LW])
      );
    end
  endgenerate

  // Clear FSM: one address per cycle, clr_addr parks on the last address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT_CLEAR ? CLEAR : READY;
      clr_addr <= '0;
      busy_q   <= INIT_CLEAR;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_addr == LAST) begin
            state  <= READY;
            busy_q <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end

  // Read pipeline. Data is frozen (with forwarding applied) at the first
  // edge, so later writes cannot disturb an in-flight read. Each stage only
  // loads when its valid bit moves, so R0_data holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[1] <= rd_fire;
      if (rd_fire) dat_q[1] <= rd_fwd;
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign bus.R0_data   = dat_q[RD_LAT];
  assign bus.R0_valid  = vld_pipe[RD_LAT];
  assign bus.init_busy = busy_q;
endmodule

// File: tb/tb_sram_1r1w_ctrl.sv
// Directed bench for sram_1r1w_ctrl: two instances (RD_LAT=1 and RD_LAT=2,
// ADDR_W=4, INIT_CLEAR=1) driven with identical stimulus. The latency-2
// instance is checked one cycle behind the latency-1 instance.
module tb_sram_1r1w_ctrl;
  logic clock;
  logic reset_n;
  int checks = 0;
  int errors = 0;

  sram_1r1w_ctrl_if #(.ADDR_W(4), .DATA_W(32), .MASK_W(4)) b1 ();
  sram_1r1w_ctrl_if #(.ADDR_W(4), .DATA_W(32), .MASK_W(4)) b2 ();

  sram_1r1w_ctrl #(.ADDR_W(4), .DATA_W(32), .MASK_W(4), .RD_LAT(1), .INIT_CLEAR(1'b1))
    dut1 (.clock(clock), .reset_n(reset_n), .bus(b1));
  sram_1r1w_ctrl #(.ADDR_W(4), .DATA_W(32), .MASK_W(4), .RD_LAT(2), .INIT_CLEAR(1'b1))
    dut2 (.clock(clock), .reset_n(reset_n), .bus(b2));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        re;
    logic [3:0]  ra;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] wm, input logic re, input logic [3:0] ra);
    b1.W0_en = we; b1.W0_addr = wa; b1.W0_data = wd; b1.W0_mask = wm;
    b1.R0_en = re; b1.R0_addr = ra;
    b2.W0_en = we; b2.W0_addr = wa; b2.W0_data = wd; b2.W0_mask = wm;
    b2.R0_en = re; b2.R0_addr = ra;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts cycles until init_busy drops (bounded); flags any R0_valid seen.
  task automatic count_busy(output int n, output logic saw_vld);
    n = 0;
    saw_vld = 1'b0;
    while (b1.init_busy && n < 100) begin
      tick();
      n++;
      if (b1.R0_valid || b2.R0_valid) saw_vld = 1'b1;
      if (b1.init_busy !== b2.init_busy) saw_vld = 1'b1;
    end
  endtask

  initial begin
    int   n;
    logic sv;

    tv[0]  = '{1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b1, 4'd0,  1'b1, 32'h0};
    tv[1]  = '{1'b1, 4'd5, 32'h11223344, 4'h5, 1'b0, 4'd0,  1'b0, 32'h0};
    tv[2]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd5,  1'b1, 32'hDE22BE44};
    tv[3]  = '{1'b1, 4'd9, 32'hAAAAAAAA, 4'hF, 1'b0, 4'd0,  1'b0, 32'hDE22BE44};
    tv[4]  = '{1'b1, 4'd9, 32'h55555555, 4'h8, 1'b1, 4'd9,  1'b1, 32'h55AAAAAA};
    tv[5]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd9,  1'b1, 32'h55AAAAAA};
    tv[6]  = '{1'b1, 4'd0, 32'h10,       4'hF, 1'b0, 4'd0,  1'b0, 32'h55AAAAAA};
    tv[7]  = '{1'b1, 4'd1, 32'h11,       4'hF, 1'b0, 4'd0,  1'b0, 32'h55AAAAAA};
    tv[8]  = '{1'b1, 4'd2, 32'h12,       4'hF, 1'b0, 4'd0,  1'b0, 32'h55AAAAAA};
    tv[9]  = '{1'b1, 4'd3, 32'h13,       4'hF, 1'b0, 4'd0,  1'b0, 32'h55AAAAAA};
    tv[10] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd0,  1'b1, 32'h10};
    tv[11] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd1,  1'b1, 32'h11};
    tv[12] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd2,  1'b1, 32'h12};
    tv[13] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3,  1'b1, 32'h13};
    tv[14] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0,  1'b0, 32'h13};
    tv[15] = '{1'b1, 4'd6, 32'hFFFFFFFF, 4'h0, 1'b1, 4'd6,  1'b1, 32'h0};
    tv[16] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd6,  1'b1, 32'h0};
    tv[17] = '{1'b0, 4'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd15, 1'b1, 32'h0};

    // Reset state
    reset_n = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    tick();
    tick();
    chk("rst_data1", b1.R0_data, 32'h0);
    chk("rst_vld1",  32'(b1.R0_valid), 32'h0);
    chk("rst_busy1", 32'(b1.init_busy), 32'h1);
    chk("rst_data2", b2.R0_data, 32'h0);
    chk("rst_busy2", 32'(b2.init_busy), 32'h1);

    // Clear takes exactly 16 cycles
    reset_n = 1'b1;
    count_busy(n, sv);
    chk("clear_cycles", 32'(n), 32'd16);
    chk("clear_no_vld", 32'(sv), 32'h0);

    // Every address reads zero after clear
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
      tick();
      chk($sformatf("clr_rd1_vld[%0d]", a), 32'(b1.R0_valid), 32'h1);
      chk($sformatf("clr_rd1_dat[%0d]", a), b1.R0_data, 32'h0);
      if (a > 0) begin
        chk($sformatf("clr_rd2_vld[%0d]", a-1), 32'(b2.R0_valid), 32'h1);
        chk($sformatf("clr_rd2_dat[%0d]", a-1), b2.R0_data, 32'h0);
      end
    end
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    tick();
    chk("clr_rd1_idle_vld", 32'(b1.R0_valid), 32'h0);
    chk("clr_rd2_vld[15]", 32'(b2.R0_valid), 32'h1);
    chk("clr_rd2_dat[15]", b2.R0_data, 32'h0);

    // Table: masked writes, collisions, back-to-back reads, hold behaviour
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].wm, tv[i].re, tv[i].ra);
      tick();
      chk($sformatf("tv1_vld[%0d]", i), 32'(b1.R0_valid), 32'(tv[i].ev));
      chk($sformatf("tv1_dat[%0d]", i), b1.R0_data, tv[i].ed);
      if (i > 0) begin
        chk($sformatf("tv2_vld[%0d]", i-1), 32'(b2.R0_valid), 32'(tv[i-1].ev));
        chk($sformatf("tv2_dat[%0d]", i-1), b2.R0_data, tv[i-1].ed);
      end
    end
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    tick();
    chk("tv2_vld[17]", 32'(b2.R0_valid), 32'(tv[17].ev));
    chk("tv2_dat[17]", b2.R0_data, tv[17].ed);

    // Read captured before a following-cycle write (addr 7 is zero)
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7);
    tick();
    chk("rw_rd1_dat", b1.R0_data, 32'h0);
    drive(1'b1, 4'd7, 32'hFFFFFFFF, 4'hF, 1'b0, 4'd0);
    tick();
    chk("rw_rd2_vld", 32'(b2.R0_valid), 32'h1);
    chk("rw_rd2_dat", b2.R0_data, 32'h0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7);
    tick();
    chk("rw_rd1_new", b1.R0_data, 32'hFFFFFFFF);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    tick();
    chk("rw_rd2_new_vld", 32'(b2.R0_valid), 32'h1);
    chk("rw_rd2_new", b2.R0_data, 32'hFFFFFFFF);
    tick();
    chk("rw_rd2_hold_vld", 32'(b2.R0_valid), 32'h0);
    chk("rw_rd2_hold", b2.R0_data, 32'hFFFFFFFF);

    // Asynchronous reset clears outputs between edges
    reset_n = 1'b0;
    #1;
    chk("arst_dat1", b1.R0_data, 32'h0);
    chk("arst_dat2", b2.R0_data, 32'h0);
    chk("arst_busy1", 32'(b1.init_busy), 32'h1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Requests during clear are dropped; reset again at clr_addr=7
    drive(1'b1, 4'd14, 32'h0000ABCD, 4'hF, 1'b1, 4'd14);
    sv = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (b1.R0_valid || b2.R0_valid || !b1.init_busy || !b2.init_busy) sv = 1'b1;
    end
    chk("busy_req_dropped", 32'(sv), 32'h0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy1", 32'(b1.init_busy), 32'h1);
    chk("mid_rst_busy2", 32'(b2.init_busy), 32'h1);
    chk("mid_rst_vld1", 32'(b1.R0_valid), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    count_busy(n, sv);
    chk("reclear_cycles", 32'(n), 32'd16);
    chk("reclear_no_vld", 32'(sv), 32'h0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd14);
    tick();
    chk("post_rd1_vld", 32'(b1.R0_valid), 32'h1);
    chk("post_rd1_dat", b1.R0_data, 32'h0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5);
    tick();
    chk("post_rd2_dat14", b2.R0_data, 32'h0);
    chk("post_rd1_dat5", b1.R0_data, 32'h0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    tick();
    chk("post_rd2_dat5", b2.R0_data, 32'h0);
    chk("post_rd2_vld5", 32'(b2.R0_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
